// File: rtl/instr_fetch_mem.sv
// Loadable instruction memory for the fetch stage: program load port, registered 1-cycle fetch with stall/flush.
// Optional build macro IMEM_PARITY_EN adds a stored even-parity bit per word and a sticky parity_err flag.
module instr_fetch_mem #(
    parameter int              INSTR_W  = 9,
    parameter int              OPC_W    = 5,
    parameter int              ADDR_W   = 16,
    parameter int              DEPTH    = 64,
    parameter logic [OPC_W-1:0] HALT_OPC = 5'b11010
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  pc,
    input  logic               fetch_en,
    input  logic               flush,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               load_start,
    input  logic               load_we,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_end,
    output logic [ADDR_W-1:0]  prog_len,
    output logic               ready,
    output logic               parity_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0]  DEPTH_A   = ADDR_W'(DEPTH);
    localparam logic [INSTR_W-1:0] HALT_WORD = {HALT_OPC, {(INSTR_W-OPC_W){1'b0}}};

`ifdef IMEM_PARITY_EN
    localparam int MEM_W = INSTR_W + 1;
`else
    localparam int MEM_W = INSTR_W;
`endif

    typedef enum logic [1:0] {
        S_EMPTY,
        S_LOAD,
        S_READY
    } state_t;

    state_t             state;
    logic [MEM_W-1:0]   mem [DEPTH];
    logic [MEM_W-1:0]   wr_word;
    logic [MEM_W-1:0]   rd_word;
    logic               mem_we;
    logic               pc_hit;
    logic               par_bad;
    logic               fetch_go;
    logic [INSTR_W-1:0] fetch_word;

    assign mem_we  = (state == S_LOAD) && load_we && (load_addr < DEPTH_A);
    assign rd_word = mem[pc[IDX_W-1:0]];
    // prog_len never exceeds DEPTH, so a hit also guarantees the index bits address a stored word.
    assign pc_hit  = (pc < prog_len);

`ifdef IMEM_PARITY_EN
    assign wr_word = {^load_data, load_data};
    assign par_bad = pc_hit && (^rd_word);
`else
    assign wr_word = load_data;
    assign par_bad = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign fetch_go   = (state == S_READY) && !load_start && !flush && fetch_en;
    assign fetch_word = (pc_hit && !par_bad) ? rd_word[INSTR_W-1:0] : HALT_WORD;
    assign ready      = (state == S_READY);

    // NOTE: the storage array has no reset; its contents are unreachable until prog_len covers them.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[load_addr[IDX_W-1:0]] <= wr_word;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_EMPTY;
            instr       <= '0;
            instr_valid <= 1'b0;
            prog_len    <= '0;
        end else begin
            case (state)
                S_EMPTY: begin
                    instr       <= HALT_WORD;
                    instr_valid <= 1'b0;
                    if (load_start) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    instr       <= HALT_WORD;
                    instr_valid <= 1'b0;
                    if (mem_we && (load_addr >= prog_len)) begin
                        prog_len <= load_addr + ADDR_W'(1);
                    end
                    if (load_end) begin
                        state <= S_READY;
                    end
                end
                S_READY: begin
                    if (load_start) begin
                        // Reload wins over a concurrent fetch; prog_len is kept so patching works.
                        state       <= S_LOAD;
                        instr       <= HALT_WORD;
                        instr_valid <= 1'b0;
                    end else if (flush) begin
                        instr       <= '0;
                        instr_valid <= 1'b0;
                    end else if (fetch_en) begin
                        instr       <= fetch_word;
                        instr_valid <= 1'b1;
                    end
                end
                default: begin
                    state       <= S_EMPTY;
                    instr       <= HALT_WORD;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef IMEM_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else if (fetch_go && par_bad) begin
            parity_err <= 1'b1;
        end
    end
`else
    logic unused_fetch_go;
    assign unused_fetch_go = fetch_go;
`endif

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Scoreboard bench for instr_fetch_mem: the driver queues hand-computed expectations tagged with
// the cycle they apply to; a negedge monitor pops and compares them. Parity steps need IMEM_PARITY_EN.
module tb_instr_fetch_mem;

    localparam int INSTR_W = 9;
    localparam int ADDR_W  = 16;
    localparam logic [INSTR_W-1:0] HALT = 9'h1A0;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [ADDR_W-1:0]  pc;
    logic               fetch_en;
    logic               flush;
    logic [INSTR_W-1:0] instr;
    logic               instr_valid;
    logic               load_start;
    logic               load_we;
    logic [ADDR_W-1:0]  load_addr;
    logic [INSTR_W-1:0] load_data;
    logic               load_end;
    logic [ADDR_W-1:0]  prog_len;
    logic               ready;
    logic               parity_err;

    instr_fetch_mem dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc          (pc),
        .fetch_en    (fetch_en),
        .flush       (flush),
        .instr       (instr),
        .instr_valid (instr_valid),
        .load_start  (load_start),
        .load_we     (load_we),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .load_end    (load_end),
        .prog_len    (prog_len),
        .ready       (ready),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                 cyc;
        string              name;
        logic [INSTR_W-1:0] instr;
        logic               valid;
        logic [ADDR_W-1:0]  len;
        logic               rdy;
        logic               perr;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    logic exp_perr = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: every negedge, compare the expectation due this cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc < cyc) begin
                check({e.name, "_missed"}, 32'(cyc), 32'(e.cyc));
            end else begin
                check({e.name, "_instr"}, 32'(instr), 32'(e.instr));
                check({e.name, "_valid"}, 32'(instr_valid), 32'(e.valid));
                check({e.name, "_len"},   32'(prog_len), 32'(e.len));
                check({e.name, "_ready"}, 32'(ready), 32'(e.rdy));
                check({e.name, "_perr"},  32'(parity_err), 32'(e.perr));
            end
        end
    end

    // Expectation for the outputs visible after the coming rising edge.
    task automatic expect_next(input string name, input logic [INSTR_W-1:0] i, input logic v,
                               input logic [ADDR_W-1:0] len, input logic rdy);
        exp_t e;
        e.cyc = cyc + 1; e.name = name; e.instr = i; e.valid = v;
        e.len = len; e.rdy = rdy; e.perr = exp_perr;
        q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        fetch_en = 0; flush = 0; load_start = 0; load_we = 0; load_end = 0;
        load_addr = '0; load_data = '0; pc = '0;
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] a);
        idle(); fetch_en = 1; pc = a;
    endtask

    task automatic wr(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
        idle(); load_we = 1; load_addr = a; load_data = d;
    endtask

    initial begin
        rst_n = 0;
        idle();
        tick();
        // 1: reset state, then fetch while EMPTY
        expect_next("rst", 9'h000, 0, 16'd0, 0);
        tick(); tick();
        rst_n = 1;
        fetch(16'd0);
        expect_next("empty_fetch", HALT, 0, 16'd0, 0);
        tick();

        // 2: load 0..37 with 0x0C0+i
        idle(); load_start = 1;
        expect_next("enter_load", HALT, 0, 16'd0, 0);
        tick();
        for (int i = 0; i < 38; i++) begin
            wr(ADDR_W'(i), 9'h0C0 + INSTR_W'(i));
            expect_next("load_wr", HALT, 0, ADDR_W'(i + 1), 0);
            tick();
        end
        idle(); load_end = 1;
        expect_next("load_end", HALT, 0, 16'd38, 1);
        tick();
        fetch(16'd5);
        expect_next("fetch5", 9'h0C5, 1, 16'd38, 1);
        tick();
        fetch(16'd38);
        expect_next("fetch_len", HALT, 1, 16'd38, 1);
        tick();
        fetch(16'd37);
        expect_next("fetch_last", 9'h0E5, 1, 16'd38, 1);
        tick();
        fetch(16'hFFFF);
        expect_next("fetch_max_pc", HALT, 1, 16'd38, 1);
        tick();

        // 3: stall holds the previous fetch
        fetch(16'd3);
        expect_next("fetch3", 9'h0C3, 1, 16'd38, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            idle(); pc = 16'd9;
            expect_next("stall", 9'h0C3, 1, 16'd38, 1);
            tick();
        end

        // 4: flush beats fetch_en
        fetch(16'd4); flush = 1;
        expect_next("flush", 9'h000, 0, 16'd38, 1);
        tick();
        fetch(16'd4);
        expect_next("after_flush", 9'h0C4, 1, 16'd38, 1);
        tick();
        idle(); load_end = 1; load_we = 1; load_addr = 16'd50; load_data = 9'h111;
        expect_next("ready_ignores_load", 9'h0C4, 1, 16'd38, 1);
        tick();

        // 5: reload from READY with a concurrent fetch; out-of-range write; write+end
        fetch(16'd6); load_start = 1;
        expect_next("reload", HALT, 0, 16'd38, 0);
        tick();
        wr(16'd64, 9'h055);
        expect_next("wr_oob", HALT, 0, 16'd38, 0);
        tick();
        wr(16'd2, 9'h1FF);
        expect_next("patch", HALT, 0, 16'd38, 0);
        tick();
        wr(16'd10, 9'h0AA); load_end = 1;
        expect_next("wr_end", HALT, 0, 16'd38, 1);
        tick();
        fetch(16'd10);
        expect_next("fetch10", 9'h0AA, 1, 16'd38, 1);
        tick();
        fetch(16'd2);
        expect_next("fetch_patch", 9'h1FF, 1, 16'd38, 1);
        tick();
        fetch(16'd63);
        expect_next("fetch63", HALT, 1, 16'd38, 1);
        tick();

        // 6: reset mid-LOAD after 5 writes
        idle(); load_start = 1;
        expect_next("load2", HALT, 0, 16'd38, 0);
        tick();
        idle(); load_start = 1; load_end = 0;
        tick();
        // start a fresh program length view: reset first so prog_len restarts from 0
        rst_n = 0;
        idle();
        expect_next("rst2", 9'h000, 0, 16'd0, 0);
        tick();
        rst_n = 1;
        idle(); load_start = 1;
        expect_next("load3", HALT, 0, 16'd0, 0);
        tick();
        for (int i = 0; i < 5; i++) begin
            wr(ADDR_W'(i), 9'h100 + INSTR_W'(i));
            expect_next("part_wr", HALT, 0, ADDR_W'(i + 1), 0);
            tick();
        end
        rst_n = 0;
        idle();
        expect_next("rst_mid_load", 9'h000, 0, 16'd0, 0);
        tick();
        rst_n = 1;
        idle(); load_start = 1;
        expect_next("load4", HALT, 0, 16'd0, 0);
        tick();
        wr(16'd10, 9'h0AA); load_end = 1;
        expect_next("wr_end_short", HALT, 0, 16'd11, 1);
        tick();
        fetch(16'd4);
        expect_next("stale_word", 9'h104, 1, 16'd11, 1);
        tick();
        fetch(16'd11);
        expect_next("fetch11", HALT, 1, 16'd11, 1);
        tick();

`ifdef IMEM_PARITY_EN
        idle();
        dut.mem[0][INSTR_W] = ~dut.mem[0][INSTR_W];
        fetch(16'd0);
        exp_perr = 1'b1;
        expect_next("parity_bad", HALT, 1, 16'd11, 1);
        tick();
        fetch(16'd10);
        expect_next("parity_sticky", 9'h0AA, 1, 16'd11, 1);
        tick();
`endif

        idle();
        for (int i = 0; i < 10 && q.size() > 0; i++) tick();
        if (q.size() > 0) check("drain_timeout", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
